// File: rtl/ps2_pkg.sv
// ============================================================================
// Module   : ps2_pkg
// Brief    : Scan-code constants, decoder state type and default key map for
//            the PS/2 key tracker.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package ps2_pkg;

  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;
  localparam logic [7:0] SC_AA = 8'hAA;
  localparam logic [7:0] SC_FA = 8'hFA;
  localparam logic [7:0] SC_EE = 8'hEE;
  localparam logic [7:0] SC_FE = 8'hFE;

  localparam logic [7:0] SC_D1 = 8'h16;
  localparam logic [7:0] SC_D2 = 8'h1E;
  localparam logic [7:0] SC_D3 = 8'h26;
  localparam logic [7:0] SC_D4 = 8'h25;
  localparam logic [7:0] SC_D5 = 8'h2E;
  localparam logic [7:0] SC_D6 = 8'h36;
  localparam logic [7:0] SC_D7 = 8'h3D;
  localparam logic [7:0] SC_D8 = 8'h3E;
  localparam logic [7:0] SC_D9 = 8'h46;

  // {ext, code} per channel: ch3 escape (plain 76), ch2 space, ch1 right, ch0 left.
  localparam logic [35:0] KEY_CODES_DEFAULT = {9'h076, 9'h029, 9'h174, 9'h16B};

  typedef enum logic [1:0] {
    DEC_IDLE     = 2'd0,
    DEC_GOT_E0   = 2'd1,
    DEC_GOT_F0   = 2'd2,
    DEC_GOT_E0F0 = 2'd3
  } dec_state_t;

  function automatic logic [3:0] digit_level(input logic [7:0] c);
    logic [3:0] lvl;
    case (c)
      SC_D1:   lvl = 4'd1;
      SC_D2:   lvl = 4'd2;
      SC_D3:   lvl = 4'd3;
      SC_D4:   lvl = 4'd4;
      SC_D5:   lvl = 4'd5;
      SC_D6:   lvl = 4'd6;
      SC_D7:   lvl = 4'd7;
      SC_D8:   lvl = 4'd8;
      SC_D9:   lvl = 4'd9;
      default: lvl = 4'd0;
    endcase
    return lvl;
  endfunction

  // Keyboard status/acknowledge bytes that never carry key information.
  function automatic logic is_ignored(input logic [7:0] c);
    return (c == SC_AA) || (c == SC_FA) || (c == SC_EE) || (c == SC_FE) ||
           (c == 8'h00) || (c == 8'hFF);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_frame_rx.sv
// ============================================================================
// Module   : ps2_frame_rx
// Brief    : PS/2 line conditioning and 11-bit frame receiver with timeout.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);

  logic [1:0]    clk_sync_q, data_sync_q;
  logic          filt_q;
  logic [FW-1:0] filt_cnt_q;
  logic [3:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          parity_q;
  logic [TW-1:0] idle_cnt_q;
  logic          byte_valid_q, frame_err_q;

  logic filt_flip, fall, timeout, frame_ok;

  always_comb begin
    filt_flip = (clk_sync_q[1] != filt_q) && (filt_cnt_q == FILT_LAST);
    fall      = filt_flip && filt_q;
    timeout   = (bit_cnt_q != 4'd0) && !fall && (idle_cnt_q == TO_LAST);
    frame_ok  = data_sync_q[1] && (^{shift_q, parity_q});
  end

  // Synchronisers reset high so a reset never fakes a falling edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= 1'b1;
      filt_cnt_q  <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      if (clk_sync_q[1] == filt_q) begin
        filt_cnt_q <= '0;
      end else if (filt_flip) begin
        filt_q     <= clk_sync_q[1];
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bit_cnt_q    <= 4'd0;
      shift_q      <= 8'h00;
      parity_q     <= 1'b0;
      idle_cnt_q   <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (fall) begin
        idle_cnt_q <= '0;
        case (bit_cnt_q)
          4'd0: if (!data_sync_q[1]) bit_cnt_q <= 4'd1;
          4'd9: begin
            parity_q  <= data_sync_q[1];
            bit_cnt_q <= 4'd10;
          end
          4'd10: begin
            bit_cnt_q <= 4'd0;
            if (frame_ok) byte_valid_q <= 1'b1;
            else          frame_err_q  <= 1'b1;
          end
          default: begin
            shift_q   <= {data_sync_q[1], shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end
        endcase
      end else if (timeout) begin
        bit_cnt_q   <= 4'd0;
        idle_cnt_q  <= '0;
        frame_err_q <= 1'b1;
      end else if (bit_cnt_q != 4'd0) begin
        idle_cnt_q <= idle_cnt_q + TW'(1);
      end else begin
        idle_cnt_q <= '0;
      end
    end
  end

  assign byte_o       = shift_q;
  assign byte_valid_o = byte_valid_q;
  assign frame_err_o  = frame_err_q;

endmodule

`default_nettype wire

// File: rtl/ps2_key_tracker.sv
// ============================================================================
// Module   : ps2_key_tracker
// Brief    : PS/2 scan-code decoder with held-key channels and level select.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int                    NUM_KEYS    = 4,
  parameter logic [NUM_KEYS*9-1:0] KEY_CODES   = KEY_CODES_DEFAULT,
  parameter int                    FILTER_LEN  = 8,
  parameter int                    TIMEOUT_CYC = 200000,
  parameter int                    LEVEL_RESET = 1
) (
  input  logic                CLK100MHZ,
  input  logic                rst,
  input  logic                PS2_CLK,
  input  logic                PS2_DATA,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [3:0]          level,
  output logic                code_valid,
  output logic [7:0]          code,
  output logic                code_ext,
  output logic                code_break,
  output logic                frame_err
);

  localparam logic [3:0] LEVEL_INIT = 4'(LEVEL_RESET);

  logic [7:0] rx_byte;
  logic       rx_valid, rx_err;

  ps2_frame_rx #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .clk_i        (CLK100MHZ),
    .rst_i        (rst),
    .ps2_clk_i    (PS2_CLK),
    .ps2_data_i   (PS2_DATA),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_valid),
    .frame_err_o  (rx_err)
  );

  dec_state_t state_q, state_d;
  logic       emit_d, ext_d, brk_d;

  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) state_q <= DEC_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    emit_d  = 1'b0;
    ext_d   = 1'b0;
    brk_d   = 1'b0;
    if (rx_err) begin
      state_d = DEC_IDLE;
    end else if (rx_valid) begin
      case (state_q)
        DEC_IDLE: begin
          if (rx_byte == SC_E0)       state_d = DEC_GOT_E0;
          else if (rx_byte == SC_F0)  state_d = DEC_GOT_F0;
          else if (!is_ignored(rx_byte)) emit_d = 1'b1;
        end
        DEC_GOT_E0: begin
          if (rx_byte == SC_F0)       state_d = DEC_GOT_E0F0;
          else if (rx_byte != SC_E0) begin
            emit_d = 1'b1;
            ext_d  = 1'b1;
          end
        end
        DEC_GOT_F0: begin
          emit_d = 1'b1;
          brk_d  = 1'b1;
        end
        DEC_GOT_E0F0: begin
          emit_d = 1'b1;
          ext_d  = 1'b1;
          brk_d  = 1'b1;
        end
        default: state_d = DEC_IDLE;
      endcase
      if (emit_d) state_d = DEC_IDLE;
    end
  end

  logic       code_valid_q, code_ext_q, code_break_q;
  logic [7:0] code_q;

  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      code_valid_q <= 1'b0;
      code_q       <= 8'h00;
      code_ext_q   <= 1'b0;
      code_break_q <= 1'b0;
    end else begin
      code_valid_q <= emit_d;
      if (emit_d) begin
        code_q       <= rx_byte;
        code_ext_q   <= ext_d;
        code_break_q <= brk_d;
      end
    end
  end

  logic [NUM_KEYS-1:0] match;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    assign match[i] = code_valid_q && (KEY_CODES[9*i +: 9] == {code_ext_q, code_q});
  end

  logic [NUM_KEYS-1:0] held_q, press_q, release_q;
  logic [3:0]          level_q;

  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      held_q    <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (match[i]) begin
          if (!code_break_q) begin
            held_q[i]  <= 1'b1;
            press_q[i] <= !held_q[i];
          end else if (held_q[i]) begin
            held_q[i]    <= 1'b0;
            release_q[i] <= 1'b1;
          end
        end
      end
    end
  end

  // Only plain digit makes move the level; a zero lookup means "not a digit".
  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      level_q <= LEVEL_INIT;
    end else if (code_valid_q && !code_ext_q && !code_break_q &&
                 (digit_level(code_q) != 4'd0)) begin
      level_q <= digit_level(code_q);
    end
  end

  assign key_held    = held_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign level       = level_q;
  assign code_valid  = code_valid_q;
  assign code        = code_q;
  assign code_ext    = code_ext_q;
  assign code_break  = code_break_q;
  assign frame_err   = rx_err;

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_tracker.sv
// ============================================================================
// Module   : tb_ps2_key_tracker
// Brief    : Directed self-checking bench for ps2_key_tracker.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ps2_key_tracker;

  // PS/2 clock is compressed (40 system cycles per half period) to keep runtime short.
  localparam int HALF = 40;
  localparam int TO   = 2000;

  logic       CLK100MHZ = 1'b0;
  logic       rst       = 1'b1;
  logic       PS2_CLK   = 1'b1;
  logic       PS2_DATA  = 1'b1;
  logic [3:0] key_held, key_press, key_release, level;
  logic       code_valid, code_ext, code_break, frame_err;
  logic [7:0] code;

  int checks = 0;
  int errors = 0;
  int n_cv = 0, n_fe = 0;
  int n_press [4];
  int n_rel   [4];
  int s_cv, s_fe, s_p, s_r;

  ps2_key_tracker #(
    .NUM_KEYS    (4),
    .FILTER_LEN  (8),
    .TIMEOUT_CYC (TO),
    .LEVEL_RESET (1)
  ) dut (
    .CLK100MHZ   (CLK100MHZ),
    .rst         (rst),
    .PS2_CLK     (PS2_CLK),
    .PS2_DATA    (PS2_DATA),
    .key_held    (key_held),
    .key_press   (key_press),
    .key_release (key_release),
    .level       (level),
    .code_valid  (code_valid),
    .code        (code),
    .code_ext    (code_ext),
    .code_break  (code_break),
    .frame_err   (frame_err)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  initial begin
    for (int k = 0; k < 4; k++) begin
      n_press[k] = 0;
      n_rel[k]   = 0;
    end
  end

  always @(negedge CLK100MHZ) begin
    if (!rst) begin
      if (code_valid) n_cv++;
      if (frame_err)  n_fe++;
      for (int k = 0; k < 4; k++) begin
        if (key_press[k])   n_press[k]++;
        if (key_release[k]) n_rel[k]++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK100MHZ);
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    PS2_DATA = b;
    if (glitch) begin
      wait_cyc(HALF / 2);
      PS2_CLK = 1'b0;
      wait_cyc(3);
      PS2_CLK = 1'b1;
      wait_cyc(HALF / 2 - 3);
    end else begin
      wait_cyc(HALF);
    end
    PS2_CLK = 1'b0;
    wait_cyc(HALF);
    PS2_CLK = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par,
                            input int glitch_bit, input int nbits);
    logic [10:0] bits;
    bits = {1'b1, (~^d) ^ bad_par, d, 1'b0};
    for (int b = 0; b < nbits; b++) send_bit(bits[b], b == glitch_bit);
    PS2_DATA = 1'b1;
    wait_cyc(HALF);
  endtask

  task automatic send(input logic [7:0] d);
    send_frame(d, 1'b0, -1, 11);
  endtask

  initial begin
    wait_cyc(10);
    check("rst_held",    32'(key_held),    32'h0);
    check("rst_press",   32'(key_press),   32'h0);
    check("rst_release", 32'(key_release), 32'h0);
    check("rst_level",   32'(level),       32'h1);
    check("rst_cv",      32'(code_valid),  32'h0);
    check("rst_code",    32'({code_ext, code_break, code}), 32'h0);
    check("rst_ferr",    32'(frame_err),   32'h0);
    rst = 1'b0;
    wait_cyc(20);

    // Plain code not mapped to any channel
    s_cv = n_cv;
    send(8'h1C);
    check("c1c_cv",   32'(n_cv - s_cv), 32'd1);
    check("c1c_code", 32'(code),        32'h1C);
    check("c1c_ext",  32'(code_ext),    32'h0);
    check("c1c_brk",  32'(code_break),  32'h0);
    check("c1c_held", 32'(key_held),    32'h0);

    // Left arrow: make, typematic repeat, break
    s_cv = n_cv; s_p = n_press[0]; s_r = n_rel[0];
    send(8'hE0); send(8'h6B);
    check("la_cv",    32'(n_cv - s_cv),       32'd1);
    check("la_code",  32'({code_ext, code_break, code}), 32'h26B);
    check("la_held",  32'(key_held),          32'h1);
    check("la_press", 32'(n_press[0] - s_p),  32'd1);
    send(8'hE0); send(8'h6B);
    check("la_rep_held",  32'(key_held),         32'h1);
    check("la_rep_press", 32'(n_press[0] - s_p), 32'd1);
    send(8'hE0); send(8'hF0); send(8'h6B);
    check("la_brk_code", 32'({code_ext, code_break, code}), 32'h36B);
    check("la_brk_held", 32'(key_held),        32'h0);
    check("la_brk_rel",  32'(n_rel[0] - s_r),  32'd1);
    check("la_brk_cv",   32'(n_cv - s_cv),     32'd3);

    // Parity error then good space
    s_cv = n_cv; s_fe = n_fe;
    send_frame(8'h29, 1'b1, -1, 11);
    check("par_fe",   32'(n_fe - s_fe), 32'd1);
    check("par_cv",   32'(n_cv - s_cv), 32'd0);
    check("par_held", 32'(key_held),    32'h0);
    send(8'h29);
    check("sp_held", 32'(key_held), 32'h4);
    check("sp_code", 32'(code),     32'h29);

    // Truncated frame recovered by timeout
    s_cv = n_cv; s_fe = n_fe;
    send_frame(8'h76, 1'b0, -1, 6);
    wait_cyc(TO + TO / 4);
    check("to_fe", 32'(n_fe - s_fe), 32'd1);
    check("to_cv", 32'(n_cv - s_cv), 32'd0);
    send(8'h76);
    check("esc_held", 32'(key_held), 32'hC);
    check("esc_fe",   32'(n_fe - s_fe), 32'd1);

    // Level select
    send(8'h26);
    check("lvl_make", 32'(level), 32'd3);
    send(8'hF0); send(8'h26);
    check("lvl_brk",     32'(level),      32'd3);
    check("lvl_brk_flg", 32'(code_break), 32'h1);
    send(8'hE0); send(8'h26);
    check("lvl_ext",     32'(level),    32'd3);
    check("lvl_ext_flg", 32'(code_ext), 32'h1);
    send(8'h46);
    check("lvl_9", 32'(level), 32'd9);
    send(8'h16);
    check("lvl_1", 32'(level), 32'd1);
    send(8'h3D);
    check("lvl_7", 32'(level), 32'd7);

    // Ignored status byte
    s_cv = n_cv;
    send(8'hAA);
    check("ign_cv",   32'(n_cv - s_cv), 32'd0);
    check("ign_code", 32'(code),        32'h3D);

    // Short glitch on PS2_CLK mid-frame
    s_cv = n_cv; s_fe = n_fe;
    send_frame(8'h45, 1'b0, 4, 11);
    check("gl_cv",   32'(n_cv - s_cv), 32'd1);
    check("gl_code", 32'(code),        32'h45);
    check("gl_fe",   32'(n_fe - s_fe), 32'd0);

    // Reset in the middle of a frame
    send_frame(8'h3E, 1'b0, -1, 5);
    rst = 1'b1;
    wait_cyc(5);
    check("mr_held",  32'(key_held), 32'h0);
    check("mr_level", 32'(level),    32'd1);
    check("mr_code",  32'({code_ext, code_break, code}), 32'h0);
    check("mr_cv",    32'(code_valid), 32'h0);
    rst = 1'b0;
    wait_cyc(20);
    s_cv = n_cv; s_fe = n_fe;
    send(8'h3E);
    check("mr_nxt_code",  32'(code),        32'h3E);
    check("mr_nxt_level", 32'(level),       32'd8);
    check("mr_nxt_cv",    32'(n_cv - s_cv), 32'd1);
    check("mr_nxt_fe",    32'(n_fe - s_fe), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
